// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    // One-entry holding register occupancy.
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_lane.sv
// One destination lane: a single-entry holding register with EMPTY/FULL
// state. A load while FULL is only ever issued together with a drain, so
// words stream through at one per cycle.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    lane_state_t st, st_nxt;

    // State register, synchronous reset to EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) st <= LANE_EMPTY;
        else        st <= st_nxt;
    end

    // Next state: fill on load, empty on drain without a refill.
    always_comb begin
        st_nxt = st;
        case (st)
            LANE_EMPTY: if (load)           st_nxt = LANE_FULL;
            LANE_FULL:  if (ready && !load) st_nxt = LANE_EMPTY;
            default:                        st_nxt = LANE_EMPTY;
        endcase
    end

    // Data register; keeps its last word while the lane is empty.
    always_ff @(posedge clk) begin
        if (!rst_n)    data <= '0;
        else if (load) data <= din;
    end

    assign valid = (st == LANE_FULL);

endmodule

// File: rtl/demux_4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready holding
// registers. Only the addressed lane can stall the input.
// Optional build macro: DEMUX_4_STATS_EN adds lane_count, four 8-bit
// wrapping counters of input transfers per lane.
module demux_4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3
`ifdef DEMUX_4_STATS_EN
    ,
    output logic [31:0]          lane_count
`endif
);

    logic                             accept;
    logic [NUM_LANES-1:0]             load;
    logic [NUM_LANES-1:0][WIDTH-1:0]  lane_data;

    // The addressed lane can take a word if empty or draining this cycle.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign load[i] = accept & (in_sel == SEL_W'(i));

            demux_lane #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load[i]),
                .ready (out_ready[i]),
                .din   (in_data),
                .valid (out_valid[i]),
                .data  (lane_data[i])
            );
        end
    endgenerate

    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

`ifdef DEMUX_4_STATS_EN
    logic [NUM_LANES-1:0][7:0] cnt;

    // Count input transfers per lane; fields wrap naturally at 255.
    always_ff @(posedge clk) begin
        if (!rst_n)      cnt <= '0;
        else if (accept) cnt[in_sel] <= cnt[in_sel] + 8'd1;
    end

    assign lane_count = cnt;
`endif

endmodule
